// File: rtl/load_store_multiple_sequencer.sv
// load_store_multiple_sequencer
// Sits between the D-format decoder and issue. Ordinary ops pass through a
// one-entry output register; lmw/stmw are cracked into one lwz/stw micro-op
// per register RT..31, stalling decode until the last micro-op leaves.
// Optional feature macro: LSM_INVALID_FORM_CHECK_EN (flags lmw with RA in
// [RT,31] as illegal instead of cracking it).
module load_store_multiple_sequencer #(
  parameter int opcodeWidth = 6,
  parameter int regWidth    = 5,
  parameter int immWidth    = 64,
  parameter int LMW_OPCODE  = 46,
  parameter int STMW_OPCODE = 47,
  parameter int LWZ_OPCODE  = 32,
  parameter int STW_OPCODE  = 36,
  parameter int WORD_BYTES  = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  output logic                   ready_o,
  input  logic [opcodeWidth-1:0] opcode_i,
  input  logic [regWidth-1:0]    reg1_i,
  input  logic [regWidth-1:0]    reg2_i,
  input  logic                   reg2ValOrZero_i,
  input  logic [immWidth-1:0]    imm_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [opcodeWidth-1:0] opcode_o,
  output logic [regWidth-1:0]    reg1_o,
  output logic [regWidth-1:0]    reg2_o,
  output logic                   reg2ValOrZero_o,
  output logic [immWidth-1:0]    imm_o,
  output logic                   last_o,
  output logic                   illegal_o
);

  localparam logic [opcodeWidth-1:0] LMW_OP    = opcodeWidth'(LMW_OPCODE);
  localparam logic [opcodeWidth-1:0] STMW_OP   = opcodeWidth'(STMW_OPCODE);
  localparam logic [opcodeWidth-1:0] LWZ_OP    = opcodeWidth'(LWZ_OPCODE);
  localparam logic [opcodeWidth-1:0] STW_OP    = opcodeWidth'(STW_OPCODE);
  localparam logic [immWidth-1:0]    WORD_STEP = immWidth'(WORD_BYTES);
  localparam logic [regWidth-1:0]    LAST_REG  = '1;

  typedef enum logic [1:0] {IDLE, PASS, CRACK} state_t;

  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   illegal_q, illegal_d;
  logic [opcodeWidth-1:0] opcode_q, opcode_d;
  logic [regWidth-1:0]    reg1_q, reg1_d;
  logic [regWidth-1:0]    reg2_q, reg2_d;
  logic                   reg2_zero_q, reg2_zero_d;
  logic [immWidth-1:0]    imm_q, imm_d;

  logic                   take;
  logic                   transfer;
  logic                   is_lmw;
  logic                   is_multiple;
  logic                   invalid_form;
  logic [regWidth-1:0]    reg1_next;

  // A new op may enter when the register is empty or its final micro-op is leaving now.
  assign ready_o     = !valid_q || (ready_i && last_q);
  assign take        = enable_i && ready_o;
  assign transfer    = valid_q && ready_i;
  assign is_lmw      = (opcode_i == LMW_OP);
  assign is_multiple = is_lmw || (opcode_i == STMW_OP);
  assign reg1_next   = reg1_q + regWidth'(1);

`ifdef LSM_INVALID_FORM_CHECK_EN
  // An lmw whose base register would be overwritten by the load sequence is not cracked.
  assign invalid_form = is_lmw && (reg2_i >= reg1_i);
`else
  assign invalid_form = 1'b0;
`endif

  assign valid_o         = valid_q;
  assign last_o          = last_q;
  assign illegal_o       = illegal_q;
  assign opcode_o        = opcode_q;
  assign reg1_o          = reg1_q;
  assign reg2_o          = reg2_q;
  assign reg2ValOrZero_o = reg2_zero_q;
  assign imm_o           = imm_q;

  // State and output register; reset abandons any instruction being cracked.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
      opcode_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg2_zero_q <= 1'b0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      illegal_q   <= illegal_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg2_zero_q <= reg2_zero_d;
      imm_q       <= imm_d;
    end
  end

  // Next-state: load a new op, step through a crack, or drain to idle; otherwise hold.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    last_d      = last_q;
    illegal_d   = illegal_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    reg2_zero_d = reg2_zero_q;
    imm_d       = imm_q;

    if (take) begin
      valid_d     = 1'b1;
      reg1_d      = reg1_i;
      reg2_d      = reg2_i;
      reg2_zero_d = reg2ValOrZero_i;
      imm_d       = imm_i;
      illegal_d   = 1'b0;
      if (is_multiple && !invalid_form) begin
        opcode_d = is_lmw ? LWZ_OP : STW_OP;
        last_d   = (reg1_i == LAST_REG);
        state_d  = (reg1_i == LAST_REG) ? PASS : CRACK;
      end else begin
        opcode_d  = opcode_i;
        last_d    = 1'b1;
        illegal_d = invalid_form;
        state_d   = PASS;
      end
    end else if (transfer) begin
      if (state_q == CRACK && !last_q) begin
        reg1_d = reg1_next;
        imm_d  = imm_q + WORD_STEP;
        last_d = (reg1_next == LAST_REG);
      end else begin
        valid_d   = 1'b0;
        last_d    = 1'b0;
        illegal_d = 1'b0;
        state_d   = IDLE;
      end
    end
  end

endmodule
